// File: rtl/branch_resolve_ex_pkg.sv
// Shared constants for the EX-stage branch resolution unit: datapath width,
// RV32I branch funct3 encodings and the squash FSM states.
package branch_resolve_ex_pkg;
  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_f3_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_e;
endpackage

// File: rtl/branch_resolve_ex_cmp.sv
// Combinational RV32I branch condition evaluator; reserved funct3 codes
// (010/011) resolve not-taken.
module branch_cmp
  import branch_resolve_ex_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_taken
);
  logic w_eq, w_lt, w_ltu;

  assign w_eq  = (i_rs1 == i_rs2);
  assign w_lt  = ($signed(i_rs1) < $signed(i_rs2));
  assign w_ltu = (i_rs1 < i_rs2);

  always_comb begin
    o_taken = 1'b0;
    case (i_funct3)
      F3_BEQ:  o_taken = w_eq;
      F3_BNE:  o_taken = ~w_eq;
      F3_BLT:  o_taken = w_lt;
      F3_BGE:  o_taken = ~w_lt;
      F3_BLTU: o_taken = w_ltu;
      F3_BGEU: o_taken = ~w_ltu;
      default: o_taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/branch_resolve_ex.sv
// EX-stage branch/JAL/JALR resolution with registered redirect, BTB update and
// one-instruction squash. Define BRANCH_PERF_CNT_EN to build the perf counters.
module branch_resolve_ex
  import branch_resolve_ex_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] pc_ex,
  input  logic [XLEN-1:0] imm_ex,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            pred_taken_ex,
  input  logic [XLEN-1:0] pred_target_ex,
  output logic            modify_pc_ex,
  output logic [XLEN-1:0] update_pc_ex,
  output logic            update_btb_ex,
  output logic [XLEN-1:0] btb_pc_ex,
  output logic [XLEN-1:0] jump_addr_ex,
  output logic            ex_branch_taken,
  output logic            kill_ex,
  output logic            misalign_ex,
  output logic [XLEN-1:0] branch_cnt,
  output logic [XLEN-1:0] mispredict_cnt
);
  state_e          r_state, w_state_nxt;
  logic            w_cmp_taken, w_taken, w_resolve, w_mispredict, w_misalign, w_redirect;
  logic [XLEN-1:0] w_base, w_sum, w_target, w_pc_plus4;

  branch_cmp u_cmp (
    .i_funct3 (funct3),
    .i_rs1    (rs1_val),
    .i_rs2    (rs2_val),
    .o_taken  (w_cmp_taken)
  );

  // A single adder serves both PC-relative and register-relative targets.
  assign w_base     = is_jalr ? rs1_val : pc_ex;
  assign w_sum      = w_base + imm_ex;
  assign w_target   = {w_sum[XLEN-1:1], w_sum[0] & ~is_jalr};
  assign w_pc_plus4 = pc_ex + XLEN'(4);

  assign w_taken      = is_jal | is_jalr | (is_branch & w_cmp_taken);
  assign w_resolve    = ex_valid & ~ex_stall & (is_branch | is_jal | is_jalr) & (r_state == ST_RUN);
  assign w_mispredict = (w_taken != pred_taken_ex) |
                        (w_taken & pred_taken_ex & (w_target != pred_target_ex));
  assign w_misalign   = w_taken & w_target[1];
  assign w_redirect   = w_resolve & w_mispredict & ~w_misalign;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:    if (w_redirect) w_state_nxt = ST_SQUASH;
      ST_SQUASH: if (~ex_stall)  w_state_nxt = ST_RUN;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_RUN;
    else      r_state <= w_state_nxt;
  end

  // The wrong-path instruction is in EX exactly while we sit in SQUASH.
  assign kill_ex = (r_state == ST_SQUASH);

  always_ff @(posedge clk) begin
    if (!rst) begin
      modify_pc_ex    <= 1'b0;
      update_pc_ex    <= '0;
      update_btb_ex   <= 1'b0;
      btb_pc_ex       <= '0;
      jump_addr_ex    <= '0;
      ex_branch_taken <= 1'b0;
      misalign_ex     <= 1'b0;
    end else begin
      modify_pc_ex    <= w_redirect;
      update_btb_ex   <= w_resolve & ~w_misalign;
      misalign_ex     <= w_resolve & w_misalign;
      ex_branch_taken <= w_resolve & w_taken;
      update_pc_ex    <= w_resolve ? (w_taken ? w_target : w_pc_plus4) : '0;
      btb_pc_ex       <= w_resolve ? pc_ex : '0;
      jump_addr_ex    <= w_resolve ? w_target : '0;
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  logic [XLEN-1:0] r_branch_cnt, r_mispredict_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else if (w_resolve) begin
      r_branch_cnt <= r_branch_cnt + XLEN'(1);
      if (w_mispredict) r_mispredict_cnt <= r_mispredict_cnt + XLEN'(1);
    end
  end

  assign branch_cnt     = r_branch_cnt;
  assign mispredict_cnt = r_mispredict_cnt;
`else
  assign branch_cnt     = '0;
  assign mispredict_cnt = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_ex.sv
// Self-checking bench for branch_resolve_ex: directed cases with literal
// expectations, then randomized traffic against a behavioural model.
module tb_branch_resolve_ex;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ex_valid, ex_stall, is_branch, is_jal, is_jalr, pred_taken_ex;
  logic [2:0]  funct3;
  logic [31:0] pc_ex, imm_ex, rs1_val, rs2_val, pred_target_ex;
  logic        modify_pc_ex, update_btb_ex, ex_branch_taken, kill_ex, misalign_ex;
  logic [31:0] update_pc_ex, btb_pc_ex, jump_addr_ex, branch_cnt, mispredict_cnt;

  branch_resolve_ex dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .funct3(funct3),
    .pc_ex(pc_ex), .imm_ex(imm_ex), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .pred_taken_ex(pred_taken_ex), .pred_target_ex(pred_target_ex),
    .modify_pc_ex(modify_pc_ex), .update_pc_ex(update_pc_ex), .update_btb_ex(update_btb_ex),
    .btb_pc_ex(btb_pc_ex), .jump_addr_ex(jump_addr_ex), .ex_branch_taken(ex_branch_taken),
    .kill_ex(kill_ex), .misalign_ex(misalign_ex),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model state: squashing flag and counters
  bit          m_sq;
  logic [31:0] m_bcnt, m_mcnt;
  logic        e_mod, e_btb, e_taken, e_mis;
  logic [31:0] e_upc, e_bpc, e_jaddr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit cond_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    sa = a; sb = b;
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Predict outputs from current inputs, advance one edge, compare everything.
  task automatic cycle();
    bit r, tk, mp, ma;
    logic [31:0] tgt;
    r   = rst && ex_valid && !ex_stall && (is_branch || is_jal || is_jalr) && !m_sq;
    tgt = is_jalr ? ((rs1_val + imm_ex) & 32'hFFFF_FFFE) : (pc_ex + imm_ex);
    tk  = is_jal || is_jalr || (is_branch && cond_taken(funct3, rs1_val, rs2_val));
    mp  = (tk != pred_taken_ex) || (tk && pred_taken_ex && tgt != pred_target_ex);
    ma  = tk && tgt[1];
    if (!rst) begin
      {e_mod, e_btb, e_taken, e_mis} = '0;
      e_upc = 0; e_bpc = 0; e_jaddr = 0;
      m_sq = 0; m_bcnt = 0; m_mcnt = 0;
    end else begin
      e_btb   = r && !ma;
      e_mod   = r && mp && !ma;
      e_mis   = r && ma;
      e_taken = r && tk;
      e_bpc   = r ? pc_ex : 32'd0;
      e_jaddr = r ? tgt : 32'd0;
      e_upc   = r ? (tk ? tgt : pc_ex + 32'd4) : 32'd0;
      m_sq    = m_sq ? ex_stall : e_mod;
      if (r) begin
        m_bcnt++;
        if (mp) m_mcnt++;
      end
    end
    @(posedge clk); #1;
    chk("modify_pc_ex",    modify_pc_ex,    e_mod);
    chk("update_pc_ex",    update_pc_ex,    e_upc);
    chk("update_btb_ex",   update_btb_ex,   e_btb);
    chk("btb_pc_ex",       btb_pc_ex,       e_bpc);
    chk("jump_addr_ex",    jump_addr_ex,    e_jaddr);
    chk("ex_branch_taken", ex_branch_taken, e_taken);
    chk("misalign_ex",     misalign_ex,     e_mis);
    chk("kill_ex",         kill_ex,         m_sq);
`ifdef BRANCH_PERF_CNT_EN
    chk("branch_cnt",      branch_cnt,      m_bcnt);
    chk("mispredict_cnt",  mispredict_cnt,  m_mcnt);
`else
    chk("branch_cnt",      branch_cnt,      32'd0);
    chk("mispredict_cnt",  mispredict_cnt,  32'd0);
`endif
  endtask

  task automatic drive(input int kind, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b,
                       input logic pt, input logic [31:0] ptgt);
    ex_valid = 1'b1; ex_stall = 1'b0;
    is_branch = (kind == 1); is_jal = (kind == 2); is_jalr = (kind == 3);
    funct3 = f3; pc_ex = pc; imm_ex = imm; rs1_val = a; rs2_val = b;
    pred_taken_ex = pt; pred_target_ex = ptgt;
  endtask

  task automatic idle();
    drive(0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    ex_valid = 1'b0;
  endtask

  initial begin
    int kills;
    logic [31:0] t;
    rst = 1'b0; m_sq = 0; m_bcnt = 0; m_mcnt = 0;
    idle();
    cycle();
    chk("reset kill_ex", kill_ex, 32'd0);
    chk("reset update_pc_ex", update_pc_ex, 32'd0);
    rst = 1'b1;

    // BEQ taken, predicted not-taken: redirect to 0x140, then kill
    drive(1, 3'd0, 32'h100, 32'h40, 32'd5, 32'd5, 1'b0, 32'h0);
    cycle();
    chk("beq modify", modify_pc_ex, 32'd1);
    chk("beq upc", update_pc_ex, 32'h140);
    chk("beq btb", update_btb_ex, 32'd1);
    chk("beq taken", ex_branch_taken, 32'd1);
    chk("beq kill", kill_ex, 32'd1);
    drive(0, 3'd0, 32'h104, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    cycle();
    chk("beq kill drop", kill_ex, 32'd0);
    chk("beq modify pulse", modify_pc_ex, 32'd0);

    // BLT / BLTU back-to-back, both correctly predicted
    drive(1, 3'd4, 32'h200, 32'h20, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h220);
    cycle();
    chk("blt taken", ex_branch_taken, 32'd1);
    chk("blt modify", modify_pc_ex, 32'd0);
    drive(1, 3'd6, 32'h200, 32'h20, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0);
    cycle();
    chk("bltu taken", ex_branch_taken, 32'd0);
    chk("bltu modify", modify_pc_ex, 32'd0);
    chk("bltu btb", update_btb_ex, 32'd1);
    chk("bltu upc", update_pc_ex, 32'h204);

    // JALR to misaligned target
    drive(3, 3'd0, 32'h300, 32'h0, 32'h203, 32'h0, 1'b0, 32'h0);
    cycle();
    chk("jalr misalign", misalign_ex, 32'd1);
    chk("jalr modify", modify_pc_ex, 32'd0);
    chk("jalr btb", update_btb_ex, 32'd0);
    chk("jalr jaddr", jump_addr_ex, 32'h202);
    idle();
    cycle();
    chk("jalr misalign pulse", misalign_ex, 32'd0);

    // wrong predicted target, then wrong predicted direction
    drive(1, 3'd0, 32'h100, 32'h40, 32'd7, 32'd7, 1'b1, 32'h180);
    cycle();
    chk("tgt redirect", update_pc_ex, 32'h140);
    chk("tgt modify", modify_pc_ex, 32'd1);
    idle(); cycle();
    drive(1, 3'd1, 32'h100, 32'h40, 32'd7, 32'd7, 1'b1, 32'h140);
    cycle();
    chk("dir redirect", update_pc_ex, 32'h104);
    chk("dir modify", modify_pc_ex, 32'd1);
    idle(); cycle();

    // mispredict followed by a wrong-path branch stalled 3 cycles
    drive(1, 3'd0, 32'h400, 32'h10, 32'd1, 32'd1, 1'b0, 32'h0);
    cycle();
    kills = int'(kill_ex);
    drive(1, 3'd0, 32'h404, 32'h8, 32'd2, 32'd2, 1'b0, 32'h0);
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      kills += int'(kill_ex);
      chk("stall no btb", update_btb_ex, 32'd0);
    end
    ex_stall = 1'b0;
    cycle();
    chk("stall kill cycles", kills, 32'd4);
    chk("stall kill exit", kill_ex, 32'd0);
    chk("stall no second btb", update_btb_ex, 32'd0);
    drive(1, 3'd0, 32'h500, 32'h10, 32'd3, 32'd3, 1'b1, 32'h510);
    cycle();
    chk("run after stall", update_btb_ex, 32'd1);

    // counters: 10 branches, 3 mispredicted, then reset
    rst = 1'b0; idle(); cycle(); rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1, 3'd0, 32'h600, 32'h20, 32'd9, 32'd9, (i >= 3), 32'h620);
      cycle();
      idle(); cycle();
    end
`ifdef BRANCH_PERF_CNT_EN
    chk("branch_cnt 10", branch_cnt, 32'd10);
    chk("mispredict_cnt 3", mispredict_cnt, 32'd3);
`else
    chk("branch_cnt off", branch_cnt, 32'd0);
    chk("mispredict_cnt off", mispredict_cnt, 32'd0);
`endif
    rst = 1'b0; cycle(); rst = 1'b1;
    chk("cnt reset", branch_cnt | mispredict_cnt, 32'd0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 99) != 0);
      drive(int'($urandom_range(0, 3)), 3'($urandom), $urandom & 32'hFFFF_FFFC,
            ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 63)) : (32'($urandom_range(0, 4095)) << 2),
            ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom, 32'h0,
            1'($urandom), $urandom);
      rs2_val = ($urandom_range(0, 2) == 0) ? rs1_val :
                (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) : $urandom);
      ex_valid = ($urandom_range(0, 7) != 0);
      ex_stall = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 1) == 0) begin
        t = is_jalr ? ((rs1_val + imm_ex) & 32'hFFFF_FFFE) : (pc_ex + imm_ex);
        pred_target_ex = t;
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_resolve_ex.md
# branch_resolve_ex

Execute-stage branch/jump resolution unit for the 5-stage RV32I core with BTB prediction. It evaluates conditional branches, JAL and JALR against the prediction carried down from fetch. It drives the registered PC redirect and BTB update into the fetch stage, and asserts a squash for the one wrong-path instruction already in EX. Outputs are registered to keep the compare/add path off the fetch next-PC mux.

## Interface
- XLEN, 32, datapath width
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- ex_valid  in  1  EX holds a valid instruction
- ex_stall  in  1  EX instruction held this cycle; no resolution
- is_branch / is_jal / is_jalr  in  1 each  decoded type, mutually exclusive
- funct3  in  3  branch condition
- pc_ex  in  32  PC of EX instruction
- imm_ex  in  32  sign-extended immediate
- rs1_val, rs2_val  in  32  forwarded operands
- pred_taken_ex  in  1  fetch predicted taken
- pred_target_ex  in  32  fetch predicted target
- modify_pc_ex  out  1  redirect fetch (one-cycle pulse)
- update_pc_ex  out  32  redirect target
- update_btb_ex  out  1  BTB write strobe (one-cycle pulse)
- btb_pc_ex  out  32  PC of resolved instruction (BTB index/tag)
- jump_addr_ex  out  32  resolved taken target
- ex_branch_taken  out  1  resolved direction
- kill_ex  out  1  wrong-path instruction in EX; downstream cancels writeback/memory
- misalign_ex  out  1  taken target with bit 1 set (one-cycle pulse)
- branch_cnt, mispredict_cnt  out  32 each  performance counters

## Operation
- Resolve event R = ex_valid & ~ex_stall & (is_branch|is_jal|is_jalr) & state==RUN.
- Target: branch/JAL = pc_ex + imm_ex; JALR = (rs1_val + imm_ex) & ~1. Wrap mod 2^32.
- Direction: JAL/JALR taken. Branch: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge. Codes 010/011 are not-taken.
- Mispredict = (taken != pred_taken_ex) | (taken & pred_taken_ex & target != pred_target_ex).
- On R, the registered outputs for the next cycle are:
  - update_btb_ex=1, btb_pc_ex=pc_ex, jump_addr_ex=target, ex_branch_taken=taken.
  - modify_pc_ex=mispredict, update_pc_ex = taken ? target : pc_ex+4.
- Misaligned taken target (target[1]=1): misalign_ex=1, modify_pc_ex=0, update_btb_ex=0. Trap handling is outside this block.
- FSM: RUN, SQUASH.
  - RUN -> SQUASH when R and modify_pc_ex will assert.
  - SQUASH: kill_ex=1 and no resolution. Exit to RUN on the first cycle with ~ex_stall; kill_ex stays high through that cycle.
- Not resolved in SQUASH: ex_valid=0, ex_stall=1, and non-control instructions.

## Timing
- Resolution latency 1: inputs sampled at edge N; outputs valid in cycle N+1 for one cycle only, then return to 0.
- Redirect in cycle N+1 loads the PC at edge N+2. Exactly one younger instruction reaches EX before the flush and is killed.
- Reset (rst=0 at an edge): state RUN; all pulse outputs and kill_ex 0; update_pc_ex, btb_pc_ex, jump_addr_ex 0; counters 0. Reset mid-SQUASH returns to RUN.
- A held EX instruction (ex_stall=1 for k cycles) resolves once, on the cycle stall drops.
- Back-to-back correctly predicted branches resolve on consecutive cycles with no bubble.

## Configuration
- BRANCH_PERF_CNT_EN defined:
  - branch_cnt increments on each R.
  - mispredict_cnt increments on each R with mispredict.
  - Both wrap at 2^32.
- BRANCH_PERF_CNT_EN undefined: no counter flops; both outputs tied to 0.

## Structure
- Shared package: funct3 branch encodings, FSM state enum (RUN/SQUASH), XLEN constant.
- One sub-module: branch_cmp, combinational; funct3 + operands -> taken.
- Registers, FSM and counters live in the top.

## Test plan
- BEQ, rs1=rs2=5, pc=0x100, imm=0x40, pred not taken -> next cycle modify_pc_ex=1, update_pc_ex=0x140, update_btb_ex=1, ex_branch_taken=1; kill_ex=1 for the following cycle.
- BLT rs1=0xFFFFFFFF, rs2=1 -> taken. BLTU with the same operands -> not taken. Both predicted correctly -> modify_pc_ex=0.
- JALR rs1=0x203, imm=0 -> target 0x202, misalign_ex=1, modify_pc_ex=0, update_btb_ex=0.
- Predicted taken to 0x180, actual taken to 0x140 -> redirect to 0x140. Predicted taken, actual not taken at pc=0x100 -> redirect to 0x104.
- Mispredicting branch, then ex_stall=1 for 3 cycles on the wrong-path instruction -> kill_ex held 4 cycles; no second update_btb_ex; RUN after stall drops.
- With BRANCH_PERF_CNT_EN: 10 branches, 3 mispredicted -> branch_cnt=10, mispredict_cnt=3. Assert rst=0 -> both 0 at the next edge.
